mouse_cursor_tracker: RTL and testbench

MOUSE_CURSOR_TRACKER -- requirements
Module: mouse_cursor_tracker

---
 rtl/mouse_cursor_tracker.sv | 199 +++++++++++++++++++
 tb/tb_mouse_cursor_tracker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mouse_cursor_tracker.sv
// PS/2 mouse packet to clamped screen-cursor tracker (IDLE/CAPTURE/COMPUTE/UPDATE).
// Optional MOUSE_STATUS_CHECK_EN rejects packets whose Status_in[3] marker bit is 0.
module mouse_cursor_tracker #(
   parameter int X_MAX  = 639,
   parameter int Y_MAX  = 479,
   parameter int X_HOME = 320,
   parameter int Y_HOME = 240
) (
   input  logic       Clock_100MHz,
   input  logic       Clear_n,
   input  logic       Data_reporting_pass,
   input  logic       Packet_valid,
   input  logic [7:0] Status_in,
   input  logic [7:0] X_Direction,
   input  logic [7:0] Y_Direction,
   output logic [9:0] Cursor_X,
   output logic [8:0] Cursor_Y,
   output logic [2:0] Buttons,
   output logic       Cursor_update,
   output logic       Packet_error
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      COMPUTE = 2'd2,
      UPDATE  = 2'd3
   } state_t;

   localparam logic [9:0]        X_HOME_C = 10'(X_HOME);
   localparam logic [8:0]        Y_HOME_C = 9'(Y_HOME);
   localparam logic [9:0]        X_MAX_C  = 10'(X_MAX);
   localparam logic [8:0]        Y_MAX_C  = 9'(Y_MAX);
   localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
   localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);

   state_t            state_q, state_d;
   logic [2:0]        btn_q, btn_d;
   logic              xsign_q, xsign_d, ysign_q, ysign_d;
   logic              xovf_q, xovf_d, yovf_q, yovf_d;
   logic [7:0]        xdir_q, xdir_d, ydir_q, ydir_d;
   logic signed [8:0] dx_q, dx_d, dy_q, dy_d;
   logic [9:0]        nx_q, nx_d;
   logic [8:0]        ny_q, ny_d;
   logic [9:0]        cursor_x_q, cursor_x_d;
   logic [8:0]        cursor_y_q, cursor_y_d;
   logic [2:0]        buttons_q, buttons_d;
   logic              update_q, update_d;
   logic              error_q, error_d;

   logic              status_ok_s;
   logic              accept_s;
   logic              reject_s;
   logic signed [11:0] sum_x_s;
   logic signed [11:0] sum_y_s;

   function automatic logic [9:0] clamp_x(input logic signed [11:0] v);
      if (v < 12'sd0)        return 10'd0;
      else if (v > X_MAX_S)  return X_MAX_C;
      else                   return v[9:0];
   endfunction

   function automatic logic [8:0] clamp_y(input logic signed [11:0] v);
      if (v < 12'sd0)        return 9'd0;
      else if (v > Y_MAX_S)  return Y_MAX_C;
      else                   return v[8:0];
   endfunction

`ifdef MOUSE_STATUS_CHECK_EN
   assign status_ok_s = Status_in[3];
`else
   // Marker bit is a don't-care in this build; OR-ing keeps it formally read.
   assign status_ok_s = Status_in[3] | 1'b1;
`endif

   assign accept_s = Packet_valid & Data_reporting_pass & status_ok_s;
   assign reject_s = Packet_valid & Data_reporting_pass & ~status_ok_s;

   // PS/2 +Y points up while screen rows grow downward, hence the subtraction.
   assign sum_x_s = $signed({2'b00, cursor_x_q}) + $signed({{3{dx_q[8]}}, dx_q});
   assign sum_y_s = $signed({3'b000, cursor_y_q}) - $signed({{3{dy_q[8]}}, dy_q});

   // State and datapath registers
   always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
      if (!Clear_n) begin
         state_q    <= IDLE;
         btn_q      <= 3'b000;
         xsign_q    <= 1'b0;
         ysign_q    <= 1'b0;
         xovf_q     <= 1'b0;
         yovf_q     <= 1'b0;
         xdir_q     <= 8'h00;
         ydir_q     <= 8'h00;
         dx_q       <= 9'sd0;
         dy_q       <= 9'sd0;
         nx_q       <= 10'd0;
         ny_q       <= 9'd0;
         cursor_x_q <= X_HOME_C;
         cursor_y_q <= Y_HOME_C;
         buttons_q  <= 3'b000;
         update_q   <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         btn_q      <= btn_d;
         xsign_q    <= xsign_d;
         ysign_q    <= ysign_d;
         xovf_q     <= xovf_d;
         yovf_q     <= yovf_d;
         xdir_q     <= xdir_d;
         ydir_q     <= ydir_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         nx_q       <= nx_d;
         ny_q       <= ny_d;
         cursor_x_q <= cursor_x_d;
         cursor_y_q <= cursor_y_d;
         buttons_q  <= buttons_d;
         update_q   <= update_d;
         error_q    <= error_d;
      end
   end

   // Next-state logic; packets arriving outside IDLE are dropped
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_s) state_d = CAPTURE;
            else          state_d = IDLE;
         end
         CAPTURE: state_d = COMPUTE;
         COMPUTE: state_d = UPDATE;
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-state datapath and output pulse values
   always_comb begin
      btn_d      = btn_q;
      xsign_d    = xsign_q;
      ysign_d    = ysign_q;
      xovf_d     = xovf_q;
      yovf_d     = yovf_q;
      xdir_d     = xdir_q;
      ydir_d     = ydir_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      nx_d       = nx_q;
      ny_d       = ny_q;
      cursor_x_d = cursor_x_q;
      cursor_y_d = cursor_y_q;
      buttons_d  = buttons_q;
      update_d   = 1'b0;
      error_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               btn_d   = Status_in[2:0];
               xsign_d = Status_in[4];
               ysign_d = Status_in[5];
               xovf_d  = Status_in[6];
               yovf_d  = Status_in[7];
               xdir_d  = X_Direction;
               ydir_d  = Y_Direction;
            end else begin
               error_d = reject_s;
            end
         end
         CAPTURE: begin
            if (xovf_q) dx_d = 9'sd0;
            else        dx_d = $signed({xsign_q, xdir_q});
            if (yovf_q) dy_d = 9'sd0;
            else        dy_d = $signed({ysign_q, ydir_q});
         end
         COMPUTE: begin
            nx_d = clamp_x(sum_x_s);
            ny_d = clamp_y(sum_y_s);
         end
         UPDATE: begin
            cursor_x_d = nx_q;
            cursor_y_d = ny_q;
            buttons_d  = btn_q;
            update_d   = 1'b1;
         end
         default: begin
            update_d = 1'b0;
         end
      endcase
   end

   assign Cursor_X      = cursor_x_q;
   assign Cursor_Y      = cursor_y_q;
   assign Buttons       = buttons_q;
   assign Cursor_update = update_q;
   assign Packet_error  = error_q;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Directed, table-driven bench for mouse_cursor_tracker (honours MOUSE_STATUS_CHECK_EN).
module tb_mouse_cursor_tracker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pass = 1'b0;
   logic       pv = 1'b0;
   logic [7:0] st = 8'h00;
   logic [7:0] xd = 8'h00;
   logic [7:0] yd = 8'h00;
   logic [9:0] cx;
   logic [8:0] cy;
   logic [2:0] btn;
   logic       upd;
   logic       perr;

   int checks = 0;
   int failures = 0;

   mouse_cursor_tracker dut (
      .Clock_100MHz        (clk),
      .Clear_n             (rst_n),
      .Data_reporting_pass (pass),
      .Packet_valid        (pv),
      .Status_in           (st),
      .X_Direction         (xd),
      .Y_Direction         (yd),
      .Cursor_X            (cx),
      .Cursor_Y            (cy),
      .Buttons             (btn),
      .Cursor_update       (upd),
      .Packet_error        (perr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] st;
      logic [7:0] xd;
      logic [7:0] yd;
      logic       pass;
      int         ex;
      int         ey;
      int         eb;
      int         eupd;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Called at a negedge: present one packet for one cycle, then watch 6 negedges.
   task automatic run_pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y,
                          input logic p, input logic p_after,
                          output int upd_cnt, output int upd_at, output int err_cnt);
      st = s; xd = x; yd = y; pass = p; pv = 1'b1;
      @(negedge clk);
      pv = 1'b0; pass = p_after;
      upd_cnt = 0; upd_at = -1; err_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         if (upd) begin
            upd_cnt++;
            if (upd_at < 0) upd_at = i;
         end
         if (perr) err_cnt++;
      end
   endtask

   initial begin
      int uc, ua, ec;
      string tag;

      vecs[0]  = '{8'h09, 8'h0A, 8'h05, 1'b1, 330, 235, 1, 1};
      vecs[1]  = '{8'h09, 8'h50, 8'h50, 1'b0, 330, 235, 1, 0};
      vecs[2]  = '{8'h08, 8'h00, 8'h00, 1'b1, 330, 235, 0, 1};
      vecs[3]  = '{8'h18, 8'h00, 8'h00, 1'b1,  74, 235, 0, 1};
      vecs[4]  = '{8'h18, 8'h00, 8'h00, 1'b1,   0, 235, 0, 1};
      vecs[5]  = '{8'h08, 8'h00, 8'h80, 1'b1,   0, 107, 0, 1};
      vecs[6]  = '{8'h08, 8'h00, 8'h80, 1'b1,   0,   0, 0, 1};
      vecs[7]  = '{8'h48, 8'h7F, 8'h00, 1'b1,   0,   0, 0, 1};
      vecs[8]  = '{8'h08, 8'h7F, 8'h00, 1'b1, 127,   0, 0, 1};
      vecs[9]  = '{8'h28, 8'h00, 8'h01, 1'b1, 127, 255, 0, 1};
      vecs[10] = '{8'h28, 8'h00, 8'h01, 1'b1, 127, 479, 0, 1};
      vecs[11] = '{8'h88, 8'h00, 8'h01, 1'b1, 127, 479, 0, 1};
      vecs[12] = '{8'h0F, 8'h7F, 8'h00, 1'b1, 254, 479, 7, 1};
      vecs[13] = '{8'h0F, 8'h7F, 8'h00, 1'b1, 381, 479, 7, 1};
      vecs[14] = '{8'h0F, 8'h7F, 8'h00, 1'b1, 508, 479, 7, 1};
      vecs[15] = '{8'h0F, 8'h7F, 8'h00, 1'b1, 635, 479, 7, 1};
      vecs[16] = '{8'h0F, 8'h7F, 8'h00, 1'b1, 639, 479, 7, 1};

      // Reset state and quiet outputs across the deassertion
      repeat (2) @(negedge clk);
      chk("rst_x", int'(cx), 320);
      chk("rst_y", int'(cy), 240);
      chk("rst_btn", int'(btn), 0);
      uc = 0; ec = 0;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (upd) uc++;
         if (perr) ec++;
      end
      chk("rst_upd_pulses", uc, 0);
      chk("rst_err_pulses", ec, 0);

      for (int k = 0; k < 17; k++) begin
         run_pkt(vecs[k].st, vecs[k].xd, vecs[k].yd, vecs[k].pass, 1'b1, uc, ua, ec);
         tag = $sformatf("v%0d", k);
         chk({tag, "_x"}, int'(cx), vecs[k].ex);
         chk({tag, "_y"}, int'(cy), vecs[k].ey);
         chk({tag, "_btn"}, int'(btn), vecs[k].eb);
         chk({tag, "_upd_cnt"}, uc, vecs[k].eupd);
         if (vecs[k].eupd > 0) chk({tag, "_latency"}, ua, 3);
         chk({tag, "_err_cnt"}, ec, 0);
      end

      // Status marker bit clear
      run_pkt(8'h01, 8'h00, 8'h00, 1'b1, 1'b1, uc, ua, ec);
`ifdef MOUSE_STATUS_CHECK_EN
      chk("stat_err_cnt", ec, 1);
      chk("stat_upd_cnt", uc, 0);
      chk("stat_btn", int'(btn), 7);
`else
      chk("stat_err_cnt", ec, 0);
      chk("stat_upd_cnt", uc, 1);
      chk("stat_btn", int'(btn), 1);
`endif
      chk("stat_x", int'(cx), 639);
      chk("stat_y", int'(cy), 479);

      // Back-to-back strobes: second one lands in CAPTURE and is dropped
      st = 8'h18; xd = 8'hF6; yd = 8'h00; pass = 1'b1; pv = 1'b1;
      @(negedge clk);
      st = 8'h0F; xd = 8'h7F; yd = 8'h7F;
      @(negedge clk);
      pv = 1'b0;
      uc = 0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         if (upd) uc++;
      end
      chk("b2b_upd_cnt", uc, 1);
      chk("b2b_x", int'(cx), 629);
      chk("b2b_y", int'(cy), 479);
      chk("b2b_btn", int'(btn), 0);

      // Data_reporting_pass dropping after acceptance must not abort the packet
      run_pkt(8'h08, 8'h01, 8'h00, 1'b1, 1'b0, uc, ua, ec);
      chk("pdrop_x", int'(cx), 630);
      chk("pdrop_upd_cnt", uc, 1);
      chk("pdrop_latency", ua, 3);

      // Asynchronous clear while the FSM is in COMPUTE
      st = 8'h18; xd = 8'h00; yd = 8'h00; pass = 1'b1; pv = 1'b1;
      @(negedge clk);
      pv = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_x", int'(cx), 320);
      chk("midrst_y", int'(cy), 240);
      chk("midrst_btn", int'(btn), 0);
      uc = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (upd) uc++;
      end
      chk("midrst_upd_cnt", uc, 0);
      rst_n = 1'b1;
      run_pkt(8'h09, 8'h0A, 8'h05, 1'b1, 1'b1, uc, ua, ec);
      chk("postrst_x", int'(cx), 330);
      chk("postrst_y", int'(cy), 235);
      chk("postrst_btn", int'(btn), 1);
      chk("postrst_upd_cnt", uc, 1);
      chk("postrst_latency", ua, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
